vsid_cam_cfg_ctrl: RTL and testbench

//  Configuration sequencer for the VSID/encap-MAC routing CAM of the NMU parser.

---
 rtl/vsid_cam_cfg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vsid_cam_cfg_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vsid_cam_cfg_ctrl.sv
// vsid_cam_cfg_ctrl: shadow/active configuration sequencer for the VSID and
// encap-MAC routing CAM. Register writes land in a shadow copy. A commit copies
// the whole shadow to the active tables in one edge, and only between packets.
// The ingress stream is gated so that no new packet starts while a commit is
// waiting for a packet boundary.
module vsid_cam_cfg_ctrl #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  localparam int NUM_BUS_BYTES = AXIS_BUS_WIDTH / 8,
  localparam int NUM_AXIS_ID   = 2 ** AXIS_ID_WIDTH
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [AXIS_BUS_WIDTH-1:0]           axis_in_tdata,
  input  logic [NUM_BUS_BYTES-1:0]            axis_in_tkeep,
  input  logic                                axis_in_tlast,
  input  logic                                axis_in_tvalid,
  output logic                                axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]           axis_out_tdata,
  output logic [NUM_BUS_BYTES-1:0]            axis_out_tkeep,
  output logic                                axis_out_tlast,
  output logic                                axis_out_tvalid,
  input  logic                                axis_out_tready,
  input  logic                                cfg_wr_en,
  input  logic [AXIS_ID_WIDTH-1:0]            cfg_wr_id,
  input  logic [1:0]                          cfg_wr_sel,
  input  logic [31:0]                         cfg_wr_data,
  output logic                                cfg_wr_ready,
  input  logic                                cfg_commit,
  output logic                                cfg_busy,
  output logic                                cfg_commit_done,
  output logic [NUM_AXIS_ID-1:0][31:0]        vsids,
  output logic [NUM_AXIS_ID-1:0]              vsid_cam_must_match,
  output logic [NUM_AXIS_ID-1:0][47:0]        mac_encap_addresses,
  output logic [NUM_AXIS_ID-1:0]              mac_encap_cam_must_match
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   in_packet_q, in_packet_d;
  logic   gate_open_s, beat_s, wr_acc_s;

  logic [NUM_AXIS_ID-1:0][31:0] sh_vsid_q, sh_vsid_d, act_vsid_q, act_vsid_d;
  logic [NUM_AXIS_ID-1:0][47:0] sh_mac_q, sh_mac_d, act_mac_q, act_mac_d;
  logic [NUM_AXIS_ID-1:0]       sh_vmust_q, sh_vmust_d, act_vmust_q, act_vmust_d;
  logic [NUM_AXIS_ID-1:0]       sh_mmust_q, sh_mmust_d, act_mmust_q, act_mmust_d;

  // A packet already in flight keeps flowing; only a new packet start waits
  // while a commit is outstanding.
  assign gate_open_s     = (state_q == ST_IDLE) | in_packet_q;
  assign beat_s          = axis_in_tvalid & axis_out_tready & gate_open_s;
  assign axis_out_tdata  = axis_in_tdata;
  assign axis_out_tkeep  = axis_in_tkeep;
  assign axis_out_tlast  = axis_in_tlast;
  assign axis_out_tvalid = axis_in_tvalid & gate_open_s;
  assign axis_in_tready  = axis_out_tready & gate_open_s;

  assign cfg_wr_ready    = (state_q == ST_IDLE);
  assign cfg_busy        = (state_q != ST_IDLE);
  assign cfg_commit_done = (state_q == ST_APPLY);
  assign wr_acc_s        = cfg_wr_en & cfg_wr_ready;

  assign vsids                    = act_vsid_q;
  assign vsid_cam_must_match      = act_vmust_q;
  assign mac_encap_addresses      = act_mac_q;
  assign mac_encap_cam_must_match = act_mmust_q;

  // Track whether the stream is between the first and last beat of a packet.
  always_comb begin
    in_packet_d = in_packet_q;
    if (beat_s) begin
      in_packet_d = ~axis_in_tlast;
    end else begin
      in_packet_d = in_packet_q;
    end
  end

  // Shadow table update from the register port, one field per accepted write.
  always_comb begin
    sh_vsid_d  = sh_vsid_q;
    sh_mac_d   = sh_mac_q;
    sh_vmust_d = sh_vmust_q;
    sh_mmust_d = sh_mmust_q;
    if (wr_acc_s) begin
      case (cfg_wr_sel)
        2'd0: sh_vsid_d[cfg_wr_id]        = cfg_wr_data;
        2'd1: sh_mac_d[cfg_wr_id][31:0]   = cfg_wr_data;
        2'd2: sh_mac_d[cfg_wr_id][47:32]  = cfg_wr_data[15:0];
        2'd3: begin
          sh_vmust_d[cfg_wr_id] = cfg_wr_data[0];
          sh_mmust_d[cfg_wr_id] = cfg_wr_data[1];
        end
        default: sh_vsid_d = sh_vsid_q;
      endcase
    end else begin
      sh_vsid_d = sh_vsid_q;
    end
  end

  // Commit FSM next state and the atomic shadow-to-active copy in APPLY.
  always_comb begin
    state_d     = state_q;
    act_vsid_d  = act_vsid_q;
    act_mac_d   = act_mac_q;
    act_vmust_d = act_vmust_q;
    act_mmust_d = act_mmust_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!in_packet_q) begin
          state_d = ST_APPLY;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_APPLY: begin
        act_vsid_d  = sh_vsid_q;
        act_mac_d   = sh_mac_q;
        act_vmust_d = sh_vmust_q;
        act_mmust_d = sh_mmust_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, packet tracking and table registers; reset aborts any commit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      in_packet_q <= 1'b0;
      sh_vsid_q   <= '0;
      sh_mac_q    <= '0;
      sh_vmust_q  <= '0;
      sh_mmust_q  <= '0;
      act_vsid_q  <= '0;
      act_mac_q   <= '0;
      act_vmust_q <= '0;
      act_mmust_q <= '0;
    end else begin
      state_q     <= state_d;
      in_packet_q <= in_packet_d;
      sh_vsid_q   <= sh_vsid_d;
      sh_mac_q    <= sh_mac_d;
      sh_vmust_q  <= sh_vmust_d;
      sh_mmust_q  <= sh_mmust_d;
      act_vsid_q  <= act_vsid_d;
      act_mac_q   <= act_mac_d;
      act_vmust_q <= act_vmust_d;
      act_mmust_q <= act_mmust_d;
    end
  end

endmodule

// File: tb/tb_vsid_cam_cfg_ctrl.sv
// Testbench for vsid_cam_cfg_ctrl: per-cycle vector table covering a commit
// in the middle of an 8-beat packet, plus directed sequences for the MAC
// shadow/commit path and for a reset while a commit is pending.
module tb_vsid_cam_cfg_ctrl;

  logic        aclk;
  logic        areset;
  logic [63:0] in_tdata;
  logic [7:0]  in_tkeep;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic        wr_en;
  logic [3:0]  wr_id;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        commit;
  logic        busy;
  logic        done;
  logic [15:0][31:0] vsids;
  logic [15:0]       vmust;
  logic [15:0][47:0] macs;
  logic [15:0]       mmust;

  int checks = 0;
  int errors = 0;

  vsid_cam_cfg_ctrl dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tlast(out_tlast),
    .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready),
    .cfg_wr_en(wr_en), .cfg_wr_id(wr_id), .cfg_wr_sel(wr_sel), .cfg_wr_data(wr_data),
    .cfg_wr_ready(wr_ready), .cfg_commit(commit), .cfg_busy(busy),
    .cfg_commit_done(done), .vsids(vsids), .vsid_cam_must_match(vmust),
    .mac_encap_addresses(macs), .mac_encap_cam_must_match(mmust)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic        we;
    logic [3:0]  id;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        cm;
    logic        tv;
    logic        tl;
    logic        ordy;
    logic [4:0]  e;      // {wr_ready, busy, done, in_tready, out_tvalid}
    logic [31:0] e_v3;
    logic        e_m3;
    logic [31:0] e_v5;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic we, logic [3:0] id, logic [1:0] sel, logic [31:0] d,
                              logic cm, logic tv, logic tl, logic ordy, logic [4:0] e,
                              logic [31:0] v3, logic m3, logic [31:0] v5);
    vec_t v;
    v.we = we; v.id = id; v.sel = sel; v.data = d; v.cm = cm; v.tv = tv; v.tl = tl;
    v.ordy = ordy; v.e = e; v.e_v3 = v3; v.e_m3 = m3; v.e_v5 = v5;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_id = 4'd0; wr_sel = 2'd0; wr_data = 32'd0; commit = 1'b0;
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  initial begin
    logic [31:0] ev3;
    areset = 1'b1; out_tready = 1'b1; in_tdata = 64'd0; in_tkeep = 8'd0;
    idle_inputs();
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    #2;

    // Reset state and pass-through behaviour.
    chk("rst_vsids_zero", {63'd0, vsids == '0}, 64'd1);
    chk("rst_macs_zero",  {63'd0, macs == '0},  64'd1);
    chk("rst_vmust",      {48'd0, vmust}, 64'd0);
    chk("rst_mmust",      {48'd0, mmust}, 64'd0);
    chk("rst_wr_ready",   {63'd0, wr_ready}, 64'd1);
    chk("rst_busy",       {63'd0, busy}, 64'd0);
    chk("rst_done",       {63'd0, done}, 64'd0);
    in_tvalid = 1'b1; in_tdata = 64'hCAFE_F00D_1234_5678; in_tkeep = 8'h5A; in_tlast = 1'b1;
    out_tready = 1'b0;
    #1;
    chk("pass_tready_lo", {63'd0, in_tready}, 64'd0);
    chk("pass_tvalid",    {63'd0, out_tvalid}, 64'd1);
    chk("pass_tdata",     out_tdata, 64'hCAFE_F00D_1234_5678);
    chk("pass_tkeep",     {56'd0, out_tkeep}, 64'h5A);
    chk("pass_tlast",     {63'd0, out_tlast}, 64'd1);
    out_tready = 1'b1;
    #1;
    chk("pass_tready_hi", {63'd0, in_tready}, 64'd1);
    in_tvalid = 1'b0; in_tlast = 1'b0;
    step();

    // Commit at beat 3 of an 8-beat packet; held write and ignored second commit.
    ev3 = 32'h00AB_CDEF;
    vecs[0]  = mk(1'b0, 4'd0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 5'b10010, 32'h0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 4'd3, 2'd0, 32'h00ABCDEF,  1'b0, 1'b1, 1'b0, 1'b1, 5'b10011, 32'h0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 4'd3, 2'd3, 32'h1,         1'b0, 1'b1, 1'b0, 1'b1, 5'b10011, 32'h0, 1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 4'd0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 5'b10011, 32'h0, 1'b0, 32'h0);
    vecs[4]  = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b1, 1'b1, 1'b0, 1'b1, 5'b01011, 32'h0, 1'b0, 32'h0);
    vecs[5]  = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b0, 5'b01001, 32'h0, 1'b0, 32'h0);
    vecs[6]  = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b1, 5'b01011, 32'h0, 1'b0, 32'h0);
    vecs[7]  = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b1, 5'b01011, 32'h0, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b1, 5'b01011, 32'h0, 1'b0, 32'h0);
    vecs[9]  = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b1, 1'b1, 5'b01011, 32'h0, 1'b0, 32'h0);
    vecs[10] = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b1, 5'b01000, 32'h0, 1'b0, 32'h0);
    vecs[11] = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b1, 5'b01100, 32'h0, 1'b0, 32'h0);
    vecs[12] = mk(1'b1, 4'd5, 2'd0, 32'hDEAD0005,  1'b0, 1'b1, 1'b0, 1'b1, 5'b10011, ev3,   1'b1, 32'h0);
    vecs[13] = mk(1'b0, 4'd0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 5'b10011, ev3,   1'b1, 32'h0);
    vecs[14] = mk(1'b0, 4'd0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 5'b10010, ev3,   1'b1, 32'h0);

    for (int i = 0; i < 15; i++) begin
      wr_en = vecs[i].we; wr_id = vecs[i].id; wr_sel = vecs[i].sel; wr_data = vecs[i].data;
      commit = vecs[i].cm; in_tvalid = vecs[i].tv; in_tlast = vecs[i].tl;
      out_tready = vecs[i].ordy; in_tdata = {32'hDA7A_0000, i};
      #2;
      chk($sformatf("v%0d_ctrl", i), {59'd0, wr_ready, busy, done, in_tready, out_tvalid},
          {59'd0, vecs[i].e});
      chk($sformatf("v%0d_vsid3", i), {32'd0, vsids[3]}, {32'd0, vecs[i].e_v3});
      chk($sformatf("v%0d_vmust3", i), {63'd0, vmust[3]}, {63'd0, vecs[i].e_m3});
      chk($sformatf("v%0d_vsid5", i), {32'd0, vsids[5]}, {32'd0, vecs[i].e_v5});
      if (vecs[i].tv) begin
        chk($sformatf("v%0d_tdata", i), out_tdata, {32'hDA7A_0000, i});
      end
      step();
    end
    idle_inputs();
    chk("flags_mac_must_after_commit", {48'd0, mmust}, 64'd0);

    // MAC written in two halves stays in the shadow until committed.
    wr_en = 1'b1; wr_id = 4'd0; wr_sel = 2'd1; wr_data = 32'h3344_5566;
    step();
    wr_sel = 2'd2; wr_data = 32'hFFFF_1122;
    step();
    idle_inputs();
    step(); step();
    chk("mac0_before_commit", {16'd0, macs[0]}, 64'd0);
    // Commit together with a same-cycle write, which is taken first.
    commit = 1'b1; wr_en = 1'b1; wr_id = 4'd7; wr_sel = 2'd0; wr_data = 32'h0000_0077;
    step();
    idle_inputs();
    #2;
    chk("cm2_c1_busy_done", {62'd0, busy, done}, 64'd2);
    step();
    #2;
    chk("cm2_c2_busy_done", {62'd0, busy, done}, 64'd3);
    chk("cm2_c2_mac0_still_old", {16'd0, macs[0]}, 64'd0);
    step();
    #2;
    chk("cm2_c3_busy_done", {62'd0, busy, done}, 64'd0);
    chk("cm2_mac0",   {16'd0, macs[0]}, 64'h0000_1122_3344_5566);
    chk("cm2_vsid7",  {32'd0, vsids[7]}, 64'h77);
    chk("cm2_vsid5",  {32'd0, vsids[5]}, 64'hDEAD_0005);
    chk("cm2_vsid3",  {32'd0, vsids[3]}, 64'h00AB_CDEF);
    chk("cm2_vmust",  {48'd0, vmust}, 64'h0008);

    // Reset while a commit is pending behind an open packet.
    step();
    in_tvalid = 1'b1; in_tlast = 1'b0; out_tready = 1'b1; commit = 1'b1;
    step();
    commit = 1'b0;
    #2;
    chk("rp_pend_busy",   {63'd0, busy}, 64'd1);
    chk("rp_pend_tready", {63'd0, in_tready}, 64'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    #2;
    chk("rp_ctrl", {59'd0, wr_ready, busy, done, in_tready, out_tvalid}, 64'b10011);
    chk("rp_vsids_zero", {63'd0, vsids == '0}, 64'd1);
    chk("rp_macs_zero",  {63'd0, macs == '0},  64'd1);
    chk("rp_must_zero",  {32'd0, vmust, mmust}, 64'd0);
    in_tvalid = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    step(); step(); step();
    #2;
    chk("rp_shadow_lost_vsids", {63'd0, vsids == '0}, 64'd1);
    chk("rp_shadow_lost_macs",  {63'd0, macs == '0},  64'd1);
    chk("rp_shadow_lost_must",  {32'd0, vmust, mmust}, 64'd0);
    chk("rp_final_idle", {62'd0, busy, wr_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
